// File: rtl/timer_ctrl_if.sv
// User-control and display-side signals of the MM:SS timer controller.
interface timer_ctrl_if;
    logic       i_set_vld;
    logic [7:0] i_set_min;
    logic [7:0] i_set_sec;
    logic       i_count_down;
    logic       i_start;
    logic       i_stop;
    logic [7:0] o_min;
    logic [7:0] o_sec;
    logic       o_running;
    logic       o_done;
    logic       o_tick;
    logic       o_set_err;

    modport master (
        output i_set_vld, i_set_min, i_set_sec, i_count_down, i_start, i_stop,
        input  o_min, o_sec, o_running, o_done, o_tick, o_set_err
    );

    modport slave (
        input  i_set_vld, i_set_min, i_set_sec, i_count_down, i_start, i_stop,
        output o_min, o_sec, o_running, o_done, o_tick, o_set_err
    );
endinterface

// File: rtl/timer_ctrl.sv
// MM:SS BCD timer sequencer: 1 Hz prescaler, IDLE/RUN/PAUSE/DONE FSM and BCD up/down stepping.
// Optional feature: define TIMER_CTRL_AUTO_RELOAD_EN to reload the last set value at each end.
module timer_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    timer_ctrl_if.slave bus
);
    localparam int            PW        = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [PW-1:0] PRESC_ZER = {PW{1'b0}};
    localparam logic [15:0]   VAL_ZERO  = 16'h0000;
    localparam logic [15:0]   VAL_MAX   = 16'h9959;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic set_valid(input logic [7:0] min, input logic [7:0] sec);
        return (min[7:4] <= 4'd9) && (min[3:0] <= 4'd9) &&
               (sec[7:4] <= 4'd5) && (sec[3:0] <= 4'd9);
    endfunction

    function automatic logic at_end(input logic [15:0] v, input logic down);
        return down ? (v == VAL_ZERO) : (v == VAL_MAX);
    endfunction

    // Borrow chain; seconds-tens wraps 0 -> 5. Never called at 00:00.
    function automatic logic [15:0] step_down(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Carry chain; seconds-tens wraps 5 -> 0. Never called at 99:59.
    function automatic logic [15:0] step_up(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd5) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = v[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    state_t        state_r;
    state_t        state_n_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_n_s;
    logic [15:0]   value_r;
    logic [15:0]   value_n_s;
    logic [15:0]   stepped_s;
    logic          tick_r;
    logic          done_r;
    logic          running_r;
    logic          set_err_r;
    logic          done_pulse_s;
    logic          tick_now_s;
    logic          set_req_s;
    logic          set_ok_s;
    logic          cur_end_s;
    logic          step_end_s;
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
    logic [15:0]   reload_r;
`endif

    assign set_req_s  = bus.i_set_vld && (state_r != ST_RUN);
    assign set_ok_s   = set_valid(bus.i_set_min, bus.i_set_sec);
    assign tick_now_s = (state_r == ST_RUN) && (presc_r == PRESC_MAX);
    assign cur_end_s  = at_end(value_r, bus.i_count_down);
    assign stepped_s  = cur_end_s ? value_r :
                        (bus.i_count_down ? step_down(value_r) : step_up(value_r));
    assign step_end_s = at_end(stepped_s, bus.i_count_down);

    assign bus.o_min     = value_r[15:8];
    assign bus.o_sec     = value_r[7:0];
    assign bus.o_running = running_r;
    assign bus.o_done    = done_r;
    assign bus.o_tick    = tick_r;
    assign bus.o_set_err = set_err_r;

    // Next-state, next-prescaler and next-value decision for the FSM.
    always_comb begin
        state_n_s    = state_r;
        presc_n_s    = presc_r;
        value_n_s    = value_r;
        done_pulse_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (tick_now_s && step_end_s) begin
                    presc_n_s = PRESC_ZER;
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
                    if (at_end(reload_r, bus.i_count_down)) begin
                        value_n_s = stepped_s;
                        state_n_s = ST_DONE;
                    end else begin
                        value_n_s    = reload_r;
                        done_pulse_s = 1'b1;
                    end
`else
                    value_n_s = stepped_s;
                    state_n_s = ST_DONE;
`endif
                end else if (bus.i_stop) begin
                    state_n_s = ST_PAUSE;
                    value_n_s = tick_now_s ? stepped_s : value_r;
                end else if (tick_now_s) begin
                    value_n_s = stepped_s;
                    presc_n_s = PRESC_ZER;
                end else begin
                    presc_n_s = presc_r + PRESC_ONE;
                end
            end
            ST_IDLE, ST_PAUSE, ST_DONE: begin
                if (bus.i_set_vld) begin
                    if (set_ok_s) begin
                        value_n_s = {bus.i_set_min, bus.i_set_sec};
                        state_n_s = ST_IDLE;
                        presc_n_s = PRESC_ZER;
                    end else begin
                        state_n_s = state_r;
                    end
                end else if (bus.i_start) begin
                    presc_n_s = PRESC_ZER;
                    state_n_s = cur_end_s ? ST_DONE : ST_RUN;
                end else begin
                    state_n_s = state_r;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, value, prescaler and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            presc_r   <= PRESC_ZER;
            value_r   <= VAL_ZERO;
            tick_r    <= 1'b0;
            done_r    <= 1'b0;
            running_r <= 1'b0;
            set_err_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            presc_r   <= presc_n_s;
            value_r   <= value_n_s;
            tick_r    <= (state_n_s == ST_RUN) && (presc_n_s == PRESC_MAX);
            done_r    <= (state_n_s == ST_DONE) || done_pulse_s;
            running_r <= (state_n_s == ST_RUN);
            set_err_r <= set_req_s && !set_ok_s;
        end
    end

`ifdef TIMER_CTRL_AUTO_RELOAD_EN
    // Reload register captures every accepted set value.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_r <= VAL_ZERO;
        end else if (set_req_s && set_ok_s) begin
            reload_r <= {bus.i_set_min, bus.i_set_sec};
        end else begin
            reload_r <= reload_r;
        end
    end
`endif
endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with TICKS_PER_SEC=4; expected post-tick values are queued
// when a run is started and compared as each tick lands.
module tb_timer_ctrl;
    localparam int TPS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] exp_q[$];
    logic tick_seen = 1'b0;

    timer_ctrl_if bus();

    timer_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // The cycle after each o_tick shows the new value: pop and compare it.
    always @(negedge clk) begin
        if (tick_seen) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq("tick_value", {16'h0, bus.o_min, bus.o_sec}, {16'h0, exp_q.pop_front()});
            end
        end
        tick_seen <= bus.o_tick;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_set(input logic [7:0] m, input logic [7:0] s);
        bus.i_set_min = m;
        bus.i_set_sec = s;
        bus.i_set_vld = 1'b1;
        step();
        bus.i_set_vld = 1'b0;
    endtask

    task automatic do_start();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic do_stop();
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
    endtask

    task automatic run_ticks(input int n, input string tag);
        int seen;
        int budget;
        seen   = 0;
        budget = n * TPS + 8;
        while (seen < n && budget > 0) begin
            step();
            budget--;
            if (bus.o_tick) seen++;
        end
        if (seen < n) check_eq({tag, "_timeout"}, 32'(seen), 32'(n));
        else step();
    endtask

    function automatic logic [15:0] cur_val();
        return {bus.o_min, bus.o_sec};
    endfunction

    initial begin
        logic [15:0] bad [2];
        bad[0] = 16'h0060;
        bad[1] = 16'h1A00;
        bus.i_set_vld    = 1'b0;
        bus.i_set_min    = 8'h00;
        bus.i_set_sec    = 8'h00;
        bus.i_count_down = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_stop       = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_eq("reset_value", 32'(cur_val()), 32'h0);
        check_eq("reset_flags", {28'h0, bus.o_running, bus.o_done, bus.o_tick, bus.o_set_err}, 32'h0);

        // First run: 01:05 down, tick timing from start.
        do_set(8'h01, 8'h05);
        check_eq("set_0105", 32'(cur_val()), 32'h0105);
        check_eq("idle_not_running", 32'(bus.o_running), 32'h0);
        exp_q.push_back(16'h0104);
        do_start();
        check_eq("running_after_start", 32'(bus.o_running), 32'h1);
        check_eq("first_tick_c1", 32'(bus.o_tick), 32'h0);
        for (int k = 2; k <= 4; k++) begin
            step();
            check_eq("first_tick_timing", 32'(bus.o_tick), (k == 4) ? 32'h1 : 32'h0);
        end
        step();
        check_eq("val_0104", 32'(cur_val()), 32'h0104);
        do_stop();

`ifndef TIMER_CTRL_AUTO_RELOAD_EN
        // 01:00 down to 00:00, then held in DONE.
        do_set(8'h01, 8'h00);
        for (int t = 59; t >= 0; t--) exp_q.push_back(to_bcd(t));
        do_start();
        run_ticks(60, "down60");
        check_eq("down_done", {30'h0, bus.o_done, bus.o_running}, 32'h2);
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq("hold_zero", {15'h0, bus.o_tick, cur_val()}, 32'h0);
        end

        // Count up across a minute and into 99:59.
        bus.i_count_down = 1'b0;
        do_set(8'h00, 8'h59);
        exp_q.push_back(16'h0100);
        do_start();
        run_ticks(1, "up_carry");
        check_eq("val_0100", 32'(cur_val()), 32'h0100);
        do_stop();
        do_set(8'h99, 8'h58);
        exp_q.push_back(16'h9959);
        do_start();
        run_ticks(1, "up_end");
        check_eq("up_done", {30'h0, bus.o_done, bus.o_running}, 32'h2);
        repeat (12) step();
        check_eq("hold_9959", 32'(cur_val()), 32'h9959);
        do_start();
        check_eq("start_at_9959", {30'h0, bus.o_done, bus.o_running}, 32'h2);
        bus.i_count_down = 1'b1;
        do_set(8'h00, 8'h00);
        check_eq("set_zero_not_done", 32'(bus.o_done), 32'h0);
        do_start();
        check_eq("start_at_zero", {30'h0, bus.o_done, bus.o_running}, 32'h2);
`else
        // Auto reload: 00:02 down reloads on reaching 00:00.
        do_set(8'h00, 8'h02);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0001);
        do_start();
        run_ticks(1, "reload_t1");
        check_eq("reload_0001", 32'(cur_val()), 32'h0001);
        run_ticks(1, "reload_t2");
        check_eq("reload_pulse", {30'h0, bus.o_done, bus.o_running}, 32'h3);
        step();
        check_eq("reload_pulse_end", {30'h0, bus.o_done, bus.o_running}, 32'h1);
        run_ticks(1, "reload_t3");
        check_eq("reload_again", {14'h0, bus.o_running, bus.o_done, cur_val()}, 32'h20001);
        do_stop();
`endif

        // Pause holds value; resume restarts the prescaler.
        bus.i_count_down = 1'b1;
        do_set(8'h00, 8'h10);
        exp_q.push_back(16'h0009);
        exp_q.push_back(16'h0008);
        do_start();
        run_ticks(2, "pause_run");
        do_stop();
        for (int k = 0; k < 40; k++) begin
            step();
            check_eq("pause_hold", {15'h0, bus.o_running, cur_val()}, 32'h0008);
        end
        exp_q.push_back(16'h0007);
        do_start();
        check_eq("resume_c1", 32'(bus.o_tick), 32'h0);
        for (int k = 2; k <= 4; k++) begin
            step();
            check_eq("resume_tick_timing", 32'(bus.o_tick), (k == 4) ? 32'h1 : 32'h0);
        end
        step();
        bus.i_stop  = 1'b1;
        bus.i_start = 1'b1;
        step();
        bus.i_stop  = 1'b0;
        bus.i_start = 1'b0;
        check_eq("stop_start_pause", 32'(bus.o_running), 32'h0);

        // Invalid sets are rejected with a one-cycle error.
        for (int i = 0; i < 2; i++) begin
            do_set(bad[i][15:8], bad[i][7:0]);
            check_eq("set_err_pulse", 32'(bus.o_set_err), 32'h1);
            check_eq("set_err_value", 32'(cur_val()), 32'h0007);
            step();
            check_eq("set_err_clear", 32'(bus.o_set_err), 32'h0);
        end

        // Set while running is ignored; reset mid-run clears everything.
        do_set(8'h00, 8'h30);
        do_start();
        bus.i_set_min = 8'h00;
        bus.i_set_sec = 8'h45;
        bus.i_set_vld = 1'b1;
        step();
        bus.i_set_vld = 1'b0;
        check_eq("run_set_ignored", {15'h0, bus.o_set_err, cur_val()}, 32'h0030);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrun_rst_value", 32'(cur_val()), 32'h0);
        check_eq("midrun_rst_flags", {28'h0, bus.o_running, bus.o_done, bus.o_tick, bus.o_set_err}, 32'h0);
        repeat (8) step();
        check_eq("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
